// File: rtl/qos_channel_selector.sv
// Selects one of four TS input channels from presence/error health, switching through a hold-off FSM.
// Optional: define QOS_NONREVERTIVE_EN to stay on a healthy active channel in priority-scan modes.
module qos_channel_selector #(
    parameter int LOSS_TIMEOUT   = 4096,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int ERR_THRESH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ts_sync,
    input  logic [3:0]  ts_err,
    input  logic        fallback_enable,
    input  logic        manual_enable,
    input  logic [1:0]  manual_channel,
    input  logic [7:0]  channel_priority,
    input  logic [19:0] reset_timer,
    input  logic        valid_config,
    output logic [1:0]  active_channel,
    output logic [3:0]  signal_present,
    output logic [7:0]  error_count_ch0,
    output logic [7:0]  error_count_ch1,
    output logic [7:0]  error_count_ch2,
    output logic [7:0]  error_count_ch3,
    output logic        switch_pulse,
    output logic        no_healthy
);
    localparam int LW = $clog2(LOSS_TIMEOUT + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_TIMEOUT);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF_CYCLES);
    localparam logic [7:0]    ERR_LIM  = 8'(ERR_THRESH);

    // state      | meaning
    // ST_STEADY  | active channel stable, candidate agrees with it
    // ST_HOLDOFF | candidate differs, waiting for it to stay stable
    typedef enum logic {ST_STEADY, ST_HOLDOFF} state_t;

    state_t        state_q, state_d;
    logic [1:0]    active_q, active_d, pending_q, pending_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          pulse_q, pulse_d, no_healthy_q, no_healthy_d;
    logic [LW-1:0] loss_q [4];
    logic [LW-1:0] loss_d [4];
    logic [3:0]    present_q, present_d;
    logic [7:0]    err_q [4];
    logic [7:0]    err_d [4];
    logic [19:0]   win_q, win_d;
    logic          fb_q, fb_d, men_q, men_d, cfg_q, cfg_d;
    logic [1:0]    mch_q, mch_d;
    logic [7:0]    prio_q, prio_d;
    logic [19:0]   rt_q, rt_d;
    logic          wrap;
    logic [3:0]    healthy;
    logic [1:0]    scan_ch, cand;

    always_comb begin
        fb_d   = fb_q;
        men_d  = men_q;
        mch_d  = mch_q;
        prio_d = prio_q;
        rt_d   = rt_q;
        if (valid_config) begin
            fb_d   = fallback_enable;
            men_d  = manual_enable;
            mch_d  = manual_channel;
            prio_d = channel_priority;
            rt_d   = reset_timer;
        end
        cfg_d = valid_config;

        // a config write restarts the error window but never clears the counts
        wrap = !valid_config && (rt_q != '0) && (win_q == rt_q - 20'd1);
        if (valid_config || wrap || rt_q == '0) win_d = '0;
        else                                    win_d = win_q + 20'd1;

        no_healthy_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ts_sync[i])                loss_d[i] = '0;
            else if (loss_q[i] == LOSS_MAX) loss_d[i] = LOSS_MAX;
            else                           loss_d[i] = loss_q[i] + LW'(1);
            present_d[i] = (loss_d[i] != LOSS_MAX);

            if (wrap)                                    err_d[i] = '0;
            else if (ts_err[i] && err_q[i] != 8'hFF)     err_d[i] = err_q[i] + 8'd1;
            else                                         err_d[i] = err_q[i];

            healthy[i] = present_q[i] && (err_q[i] < ERR_LIM);
            if (present_d[i] && (err_d[i] < ERR_LIM)) no_healthy_d = 1'b0;
        end
    end

    always_comb begin
        scan_ch = active_q;
        // walk from lowest priority up so the highest-priority healthy entry wins
        for (int k = 3; k >= 0; k--) begin
            if (healthy[prio_q[2*k +: 2]]) scan_ch = prio_q[2*k +: 2];
        end
`ifdef QOS_NONREVERTIVE_EN
        if (!cfg_q && healthy[active_q]) scan_ch = active_q;
`endif
        if (men_q) cand = (healthy[mch_q] || !fb_q) ? mch_q : scan_ch;
        else       cand = fb_q ? scan_ch : prio_q[1:0];
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        hold_d    = hold_q;
        active_d  = active_q;
        pulse_d   = 1'b0;
        hold_inc  = hold_q + HW'(1);
        if (cfg_q && cand != active_q) begin
            active_d = cand;
            pulse_d  = 1'b1;
            state_d  = ST_STEADY;
            hold_d   = '0;
        end else begin
            case (state_q)
                ST_STEADY: begin
                    if (cand != active_q) begin
                        state_d   = ST_HOLDOFF;
                        pending_d = cand;
                        hold_d    = HW'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (cand == active_q) begin
                        state_d = ST_STEADY;
                        hold_d  = '0;
                    end else if (cand != pending_q) begin
                        pending_d = cand;
                        hold_d    = HW'(1);
                    end else if (hold_inc >= HOLD_MAX) begin
                        active_d = pending_q;
                        pulse_d  = 1'b1;
                        state_d  = ST_STEADY;
                        hold_d   = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                default: state_d = ST_STEADY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_STEADY;
            pending_q    <= '0;
            hold_q       <= '0;
            active_q     <= '0;
            pulse_q      <= 1'b0;
            no_healthy_q <= 1'b1;
            present_q    <= '0;
            win_q        <= '0;
            fb_q         <= 1'b0;
            men_q        <= 1'b0;
            mch_q        <= '0;
            prio_q       <= '0;
            rt_q         <= '0;
            cfg_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                loss_q[i] <= LOSS_MAX;
                err_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            hold_q       <= hold_d;
            active_q     <= active_d;
            pulse_q      <= pulse_d;
            no_healthy_q <= no_healthy_d;
            present_q    <= present_d;
            win_q        <= win_d;
            fb_q         <= fb_d;
            men_q        <= men_d;
            mch_q        <= mch_d;
            prio_q       <= prio_d;
            rt_q         <= rt_d;
            cfg_q        <= cfg_d;
            for (int i = 0; i < 4; i++) begin
                loss_q[i] <= loss_d[i];
                err_q[i]  <= err_d[i];
            end
        end
    end

    assign active_channel  = active_q;
    assign signal_present  = present_q;
    assign error_count_ch0 = err_q[0];
    assign error_count_ch1 = err_q[1];
    assign error_count_ch2 = err_q[2];
    assign error_count_ch3 = err_q[3];
    assign switch_pulse    = pulse_q;
    assign no_healthy      = no_healthy_q;
endmodule

// File: tb/tb_qos_channel_selector.sv
// Bench for qos_channel_selector: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of presence, error windows, candidate choice and hold-off.
module tb_qos_channel_selector;
    localparam int LT   = 4096;
    localparam int HOLD = 256;
    localparam int ETH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ts_sync = '0, ts_err = '0;
    logic        fallback_enable = 1'b0, manual_enable = 1'b0, valid_config = 1'b0;
    logic [1:0]  manual_channel = '0;
    logic [7:0]  channel_priority = '0;
    logic [19:0] reset_timer = '0;
    logic [1:0]  active_channel;
    logic [3:0]  signal_present;
    logic [7:0]  error_count_ch0, error_count_ch1, error_count_ch2, error_count_ch3;
    logic        switch_pulse, no_healthy;

    qos_channel_selector #(.LOSS_TIMEOUT(LT), .HOLDOFF_CYCLES(HOLD), .ERR_THRESH(ETH)) dut (
        .clk(clk), .rst(rst), .ts_sync(ts_sync), .ts_err(ts_err),
        .fallback_enable(fallback_enable), .manual_enable(manual_enable),
        .manual_channel(manual_channel), .channel_priority(channel_priority),
        .reset_timer(reset_timer), .valid_config(valid_config),
        .active_channel(active_channel), .signal_present(signal_present),
        .error_count_ch0(error_count_ch0), .error_count_ch1(error_count_ch1),
        .error_count_ch2(error_count_ch2), .error_count_ch3(error_count_ch3),
        .switch_pulse(switch_pulse), .no_healthy(no_healthy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [3:0] sync_en = '0;

    // reference model state
    int m_age [4];
    int m_err [4];
    int m_win, m_rt, m_mch, m_active, m_run, m_prev;
    bit m_fb, m_men, m_cfg_last, m_pulse;
    logic [7:0] m_prio;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_h(input int i);
        return (m_age[i] < LT) && (m_err[i] < ETH);
    endfunction

    function automatic int m_candidate();
        int scan = m_active;
        bit found = 0;
        logic [7:0] p = m_prio;
        for (int k = 0; k < 4; k++) begin
            if (!found && m_h(int'(p[2*k +: 2]))) begin
                scan = int'(p[2*k +: 2]);
                found = 1;
            end
        end
`ifdef QOS_NONREVERTIVE_EN
        if (!m_cfg_last && m_h(m_active)) scan = m_active;
`endif
        if (m_men) return (m_h(m_mch) || !m_fb) ? m_mch : scan;
        return m_fb ? scan : int'(p[1:0]);
    endfunction

    task automatic model_step();
        int cand;
        bit wrap;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin m_age[i] = LT; m_err[i] = 0; end
            m_win = 0; m_rt = 0; m_mch = 0; m_active = 0; m_run = 0; m_prev = 0;
            m_fb = 0; m_men = 0; m_cfg_last = 0; m_pulse = 0; m_prio = '0;
            return;
        end
        cand = m_candidate();
        m_pulse = 0;
        if (m_cfg_last && cand != m_active) begin
            m_active = cand; m_pulse = 1; m_run = 0;
        end else if (cand == m_active) begin
            m_run = 0;
        end else begin
            m_run = (m_run > 0 && cand == m_prev) ? m_run + 1 : 1;
            if (m_run >= HOLD) begin m_active = cand; m_pulse = 1; m_run = 0; end
        end
        m_prev = cand;
        wrap = !valid_config && m_rt != 0 && m_win == m_rt - 1;
        for (int i = 0; i < 4; i++) begin
            m_age[i] = ts_sync[i] ? 0 : ((m_age[i] + 1 > LT) ? LT : m_age[i] + 1);
            if (wrap) m_err[i] = 0;
            else if (ts_err[i] && m_err[i] < 255) m_err[i] = m_err[i] + 1;
        end
        m_win = (valid_config || wrap || m_rt == 0) ? 0 : m_win + 1;
        if (valid_config) begin
            m_fb = fallback_enable; m_men = manual_enable; m_mch = int'(manual_channel);
            m_prio = channel_priority; m_rt = int'(reset_timer);
        end
        m_cfg_last = valid_config;
    endtask

    task automatic tick();
        int pres = 0;
        bit any_h = 0;
        for (int i = 0; i < 4; i++)
            if (sync_en[i] && (cyc % 200) == i * 13) ts_sync[i] = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (m_age[i] < LT) pres += (1 << i);
            if (m_h(i)) any_h = 1;
        end
        chk("active_channel", int'(active_channel), m_active);
        chk("signal_present", int'(signal_present), pres);
        chk("err_ch0", int'(error_count_ch0), m_err[0]);
        chk("err_ch1", int'(error_count_ch1), m_err[1]);
        chk("err_ch2", int'(error_count_ch2), m_err[2]);
        chk("err_ch3", int'(error_count_ch3), m_err[3]);
        chk("switch_pulse", int'(switch_pulse), int'(m_pulse));
        chk("no_healthy", int'(no_healthy), int'(!any_h));
        ts_sync = '0;
        ts_err = '0;
        valid_config = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] p, input bit fb, input bit men,
                       input logic [1:0] mch, input int rt);
        channel_priority = p; fallback_enable = fb; manual_enable = men;
        manual_channel = mch; reset_timer = 20'(rt); valid_config = 1'b1;
        tick();
    endtask

    initial begin
        int guard, t0, exp_rev;
`ifdef QOS_NONREVERTIVE_EN
        exp_rev = 1;
`else
        exp_rev = 0;
`endif
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_active", int'(active_channel), 0);
        chk("reset_no_healthy", int'(no_healthy), 1);
        repeat (50) tick();

        // loss of ch0 -> failover to ch1 after hold-off
        cfg(8'hE4, 1, 0, 2'd0, 0);
        sync_en = 4'b0011;
        repeat (800) tick();
        chk("start_on_ch0", int'(active_channel), 0);
        sync_en = 4'b0010;
        guard = 0;
        while (signal_present[0] !== 1'b0 && guard < 5000) begin tick(); guard++; end
        chk("ch0_loss_seen", int'(signal_present[0]), 0);
        t0 = cyc;
        guard = 0;
        while (switch_pulse !== 1'b1 && guard < 400) begin tick(); guard++; end
        chk("loss_holdoff_len", cyc - t0, HOLD);
        chk("failover_ch1", int'(active_channel), 1);

        // recovery, error-driven failover, window clear
        sync_en = 4'b0011;
        repeat (600) tick();
        chk("revert_after_recovery", int'(active_channel), exp_rev);
        for (int n = 0; n < 16; n++) begin ts_err = 4'b0001; tick(); end
        repeat (300) tick();
        chk("err_failover_ch1", int'(active_channel), 1);
        cfg(8'hE4, 1, 0, 2'd0, 1000);
        repeat (1400) tick();
        chk("revert_after_clear", int'(active_channel), exp_rev);

        // manual select, then loss with and without fallback
        sync_en = 4'b0111;
        repeat (250) tick();
        cfg(8'hE4, 0, 1, 2'd2, 0);
        tick();
        chk("manual_immediate", int'(active_channel), 2);
        sync_en = 4'b0011;
        repeat (4400) tick();
        chk("manual_no_fallback", int'(active_channel), 2);
        cfg(8'hE4, 1, 1, 2'd2, 0);
        repeat (3) tick();
        chk("manual_fallback", int'(active_channel), 0);

        // saturation and wrap/increment collision
        cfg(8'hE4, 1, 0, 2'd0, 0);
        for (int n = 0; n < 300; n++) begin ts_err = 4'b1000; tick(); end
        repeat (5) tick();
        chk("err_saturate", int'(error_count_ch3), 255);
        cfg(8'hE4, 1, 0, 2'd0, 50);
        guard = 0;
        while (m_win != 49 && guard < 60) begin tick(); guard++; end
        ts_err = 4'b1000;
        tick();
        chk("wrap_beats_inc", int'(error_count_ch3), 0);
        cfg(8'hE4, 1, 0, 2'd0, 0);

        // candidate change mid hold-off restarts the count
        sync_en = 4'b1111;
        repeat (250) tick();
        for (int n = 0; n < 16; n++) begin ts_err = 4'b0001; tick(); end
        repeat (100) tick();
        for (int n = 0; n < 16; n++) begin ts_err = 4'b0010; tick(); end
        t0 = cyc;
        guard = 0;
        while (switch_pulse !== 1'b1 && guard < 400) begin tick(); guard++; end
        chk("restart_holdoff_len", cyc - t0, HOLD);
        chk("switch_to_ch2", int'(active_channel), 2);

        // reset during hold-off discards the pending switch
        for (int n = 0; n < 16; n++) begin ts_err = 4'b0100; tick(); end
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_active", int'(active_channel), 0);
        chk("rst_pulse", int'(switch_pulse), 0);
        repeat (50) tick();

        // random traffic
        for (int c = 0; c < 20000; c++) begin
            if (c % 2500 == 0) sync_en = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 299) == 0) ts_sync[i] = 1'b1;
                if ($urandom_range(0, 47) == 0) ts_err[i] = 1'b1;
            end
            if ($urandom_range(0, 399) == 0 || $urandom_range(0, 99) == 0) begin
                channel_priority = 8'($urandom_range(0, 255));
                fallback_enable  = 1'($urandom_range(0, 1));
                manual_enable    = 1'($urandom_range(0, 1));
                manual_channel   = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: reset_timer = 20'd0;
                    1: reset_timer = 20'($urandom_range(1, 8));
                    2: reset_timer = 20'($urandom_range(50, 400));
                    default: reset_timer = 20'd1000;
                endcase
                valid_config = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 4999) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/qos_channel_selector.md
Name: qos_channel_selector

Overview:
QoS core controller that picks one of four MPEG-TS input channels as the active output source. It tracks per-channel signal presence and windowed error counts. It applies the memory-mapped configuration (fallback, manual override, priority order, error-window timer) and sequences channel switches through a hold-off state machine. Its status outputs feed the memory-mapped status registers directly.

Parameters:
LOSS_TIMEOUT, 4096, cycles without a sync pulse before a channel is declared absent (≥1)
HOLDOFF_CYCLES, 256, cycles a new candidate must stay stable before an automatic switch (≥1)
ERR_THRESH, 16, a channel with error count ≥ this is unhealthy (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ts_sync  in  4  per-channel 1-cycle pulse: valid 0x47 packet sync seen
ts_err  in  4  per-channel 1-cycle pulse: packet error (TEI/continuity)
fallback_enable  in  1  allow automatic failover
manual_enable  in  1  manual channel select
manual_channel  in  2  manually selected channel
channel_priority  in  8  four 2-bit channel IDs; [1:0] highest priority, [7:6] lowest
reset_timer  in  20  error-count clear period in cycles; 0 = never clear
valid_config  in  1  1-cycle pulse: new config on the config inputs
active_channel  out  2  selected channel
signal_present  out  4  per-channel presence
error_count_ch0..ch3  out  8 each  per-channel error counts
switch_pulse  out  1  1-cycle pulse when active_channel changes
no_healthy  out  1  no channel is currently healthy

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high. All state and outputs are registered.
- Reset values:
  - active_channel=0, signal_present=0, all error counts=0, switch_pulse=0, no_healthy=1.
  - Shadow config=0; FSM=STEADY.
  - Loss counters=LOSS_TIMEOUT; window counter=0; hold counter=0.
- Config shadow:
  - Config inputs are latched only in the cycle valid_config=1.
  - All selection logic uses the shadow, never the live inputs.
- Presence, per channel:
  - ts_sync=1 → loss counter←0 and present←1 the next cycle.
  - Otherwise the counter increments, saturating at LOSS_TIMEOUT.
  - Present drops to 0 in the cycle the counter reaches LOSS_TIMEOUT.
- Error counters:
  - 8-bit, +1 per ts_err pulse, saturating at 255.
  - Window counter counts 0..reset_timer-1. At wrap, all four counts clear to 0; clear beats a same-cycle increment.
  - reset_timer=0 → window counter held at 0, no auto-clear.
  - A valid_config pulse restarts the window counter at 0 without clearing the counts.
- Health: healthy[i] = signal_present[i] && error_count[i] < ERR_THRESH. no_healthy = ~|healthy, registered.
- Candidate (combinational from registered state):
  - Priority scan = first channel in channel_priority order, from [1:0] up, that is healthy. If none is healthy, the scan yields active_channel.
  - manual_enable=1, manual channel healthy → manual_channel.
  - manual_enable=1, manual channel unhealthy, fallback=1 → priority scan.
  - manual_enable=1, manual channel unhealthy, fallback=0 → manual_channel.
  - manual_enable=0, fallback=1 → priority scan.
  - manual_enable=0, fallback=0 → channel_priority[1:0], fixed.
  - Duplicate IDs in channel_priority are legal; the first match wins.
- FSM, state STEADY:
  - candidate≠active → HOLDOFF, latch candidate as pending, hold counter←1.
- FSM, state HOLDOFF:
  - candidate==active → STEADY (abort, no switch).
  - candidate≠pending → pending←candidate, hold counter←1.
  - Otherwise the hold counter increments. When it reaches HOLDOFF_CYCLES: active_channel←pending, switch_pulse=1 for that cycle, → STEADY.
- Config-driven switch:
  - In the cycle after valid_config, the candidate is computed from the new shadow.
  - If it differs from active, the switch happens immediately (active updated, switch_pulse=1, FSM→STEADY), bypassing hold-off.
- Mid-operation rst: immediate return to reset values next edge; any pending switch is discarded.

Optional Feature:
QOS_NONREVERTIVE_EN
- Defined: in the priority-scan modes, while active_channel is healthy the candidate stays active_channel. A switch to a higher-priority channel happens only on failure of the active channel or on a config write.
- Undefined: revertive. The scan always prefers the highest-priority healthy channel and returns to it after recovery, through hold-off.

Test Plan:
- Reset, then no stimulus → active_channel=0, signal_present=0, no_healthy=1, counts 0, switch_pulse never asserted.
- priority=8'b11_10_01_00 (0,1,2,3), fallback=1; sync on ch0,ch1 every 200 cycles → active=0. Stop ch0 sync → present[0]=0 after 4096 cycles, active=1 exactly 256 cycles later, one switch_pulse.
- Same setup; ch0 error count pushed to 16 (ERR_THRESH) with ch1 healthy → failover to 1 after hold-off. Re-enable ch0 with reset_timer=1000 → counts clear at the window wrap, revert to 0 (non-revertive build stays on 1).
- manual_enable=1, manual_channel=2 written via valid_config with ch2 healthy → active=2 the cycle after the config cycle, no hold-off. Kill ch2 with fallback=0 → active stays 2; with fallback=1 → moves to the highest-priority healthy channel.
- 300 ts_err pulses on ch3, reset_timer=0 → error_count_ch3 saturates at 255, never clears. Error pulse coincident with window wrap → count=0.
- Candidate toggles 1→2 at hold count 100 → hold restarts, switch to 2 only after 256 stable cycles. rst asserted during HOLDOFF → active=0, no switch_pulse.
